c2_mem_responder: RTL and testbench

- Memory-side responder for the C2 line bus (14-bit line address, shared 16-bit data, shared 2-bit ctrl).
- Accepts line reads and writes from the cache-side initiator and stores 128-bit lines in an internal array.
- Returns a read line as 8 beats, or acknowledges a write, after a programmable latency.
- Replaces hand-driven bus stimulus as the standard far-end model for cache bring-up.

---
 rtl/c2_mem_responder.sv | 182 ++++++++++++++++++
 tb/tb_c2_mem_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2_mem_responder.sv
// c2_mem_responder: memory-side far-end model for the C2 line bus.
// Define C2_PROTO_CHECK_EN to add the sticky proto_err protocol monitor.
module c2_mem_responder #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 16,
    parameter int BEATS   = 8,
    parameter int LATENCY = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    inout  wire  [1:0]        ctrl,
    output logic              busy
`ifdef C2_PROTO_CHECK_EN
    ,
    output logic              proto_err
`endif
);

    localparam int BW    = $clog2(BEATS);
    localparam int LW    = 8;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0]    C_RSP    = 2'd1;
    localparam logic [1:0]    C_RD     = 2'd2;
    localparam logic [1:0]    C_WR     = 2'd3;
    localparam logic [BW-1:0] LAST     = BW'(BEATS - 1);
    localparam logic [LW-1:0] LAT_INIT = LW'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_RECV,
        WR_LAT,
        WR_ACK,
        RD_LAT,
        RD_SEND
    } state_t;

    typedef logic [BEATS-1:0][DATA_W-1:0] line_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [LW-1:0]     lat_q, lat_d;
    line_t             line_q, line_d;
    logic              mem_we;
    logic              wr_ok;

    // Line store: powers up zero and is never touched by reset.
    line_t mem_q [DEPTH] = '{default: '0};

`ifdef C2_PROTO_CHECK_EN
    logic perr_q, perr_d;
    logic lat_busy_bus;

    assign wr_ok        = (ctrl == C_WR);
    assign lat_busy_bus = (ctrl == 2'd1) || (ctrl == 2'd2) || (ctrl == 2'd3);
    assign proto_err    = perr_q;
`else
    assign wr_ok = 1'b1;
`endif

    // Next-state logic: command decode, beat capture, latency countdown.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        line_d  = line_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ctrl == C_RD) begin
                    addr_d  = addr;
                    lat_d   = LAT_INIT;
                    state_d = RD_LAT;
                end else if (ctrl == C_WR) begin
                    addr_d    = addr;
                    line_d[0] = data;
                    beat_d    = BW'(1);
                    state_d   = WR_RECV;
                end
            end
            WR_RECV: begin
                if (wr_ok) begin
                    line_d[beat_q] = data;
                    beat_d         = beat_q + 1'b1;
                    if (beat_q == LAST) begin
                        mem_we  = 1'b1;
                        beat_d  = '0;
                        lat_d   = LAT_INIT;
                        state_d = WR_LAT;
                    end
                end else begin
                    beat_d  = '0;
                    state_d = IDLE;
                end
            end
            WR_LAT: begin
                if (lat_q == '0) begin
                    state_d = WR_ACK;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            WR_ACK: begin
                state_d = IDLE;
            end
            RD_LAT: begin
                if (lat_q == '0) begin
                    line_d  = mem_q[addr_q];
                    beat_d  = '0;
                    state_d = RD_SEND;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            RD_SEND: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST) begin
                    beat_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef C2_PROTO_CHECK_EN
    // Sticky error: aborted write beat or initiator driving during latency.
    always_comb begin
        perr_d = perr_q;
        if ((state_q == WR_RECV) && !wr_ok) begin
            perr_d = 1'b1;
        end
        if (((state_q == WR_LAT) || (state_q == RD_LAT)) && lat_busy_bus) begin
            perr_d = 1'b1;
        end
    end

    // Protocol error flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
`endif

    // Control state registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            line_q  <= line_d;
        end
    end

    // Commit the completed line in the cycle its last beat is captured.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= line_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign ctrl = ((state_q == WR_ACK) || (state_q == RD_SEND)) ? C_RSP : 'z;
    assign data = (state_q == RD_SEND) ? line_q[beat_q] : 'z;

endmodule

// File: tb/tb_c2_mem_responder.sv
// tb_c2_mem_responder: randomized scoreboard bench for c2_mem_responder.
// Three responders (latency 6, 2, 255) see identical initiator traffic.
module tb_c2_mem_responder;

    localparam int NI = 3;
    localparam int LATS [NI] = '{6, 2, 255};

    typedef struct {
        int          inst;
        int          cyc;
        int          kind;
        logic [15:0] d;
    } item_t;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic [13:0] addr    = '0;
    logic        tb_cen  = 1'b0;
    logic [1:0]  tb_cval = '0;
    logic        tb_den  = 1'b0;
    logic [15:0] tb_dval = '0;
    logic [NI-1:0] busy_v;
`ifdef C2_PROTO_CHECK_EN
    logic [NI-1:0] perr_v;
`endif

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    item_t        sbq [$];
    logic [127:0] ref_mem [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, bit ok,
                                logic [127:0] act, logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    function automatic bit rel(logic [15:0] v);
        return (v === 16'h0) || $isunknown(v);
    endfunction

    function automatic logic [127:0] ref_rd(logic [13:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return '0;
    endfunction

    function automatic void push(int g, int c, int k, logic [15:0] d);
        item_t it;
        it.inst = g;
        it.cyc  = c;
        it.kind = k;
        it.d    = d;
        sbq.push_back(it);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gi
        wire [15:0] data_w;
        wire [1:0]  ctrl_w;
        assign data_w = tb_den ? tb_dval : 'z;
        assign ctrl_w = tb_cen ? tb_cval : 'z;

        c2_mem_responder #(.LATENCY(LATS[g])) u_dut (
            .clk       (clk),
            .reset     (reset),
            .addr      (addr),
            .data      (data_w),
            .ctrl      (ctrl_w),
            .busy      (busy_v[g])
`ifdef C2_PROTO_CHECK_EN
            ,
            .proto_err (perr_v[g])
`endif
        );

        always @(negedge clk) begin
            int    idx;
            item_t it;
            idx = -1;
            if (reset) begin
                foreach (sbq[i]) if (idx < 0 && sbq[i].inst == g) idx = i;
                if (idx >= 0 && sbq[idx].cyc < cyc) begin
                    errors++;
                    $display("FAIL missed_item inst %0d: got none expected cyc %0d",
                             g, sbq[idx].cyc);
                    sbq.delete(idx);
                end else if (idx >= 0 && sbq[idx].cyc == cyc) begin
                    it = sbq[idx];
                    sbq.delete(idx);
                    if (it.kind == 0) begin
                        chk($sformatf("rd_beat%0d", g),
                            busy_v[g] && ctrl_w === 2'd1 && data_w === it.d,
                            128'({busy_v[g], ctrl_w, data_w}),
                            128'({1'b1, 2'd1, it.d}));
                    end else if (it.kind == 1) begin
                        chk($sformatf("wr_ack%0d", g),
                            busy_v[g] && ctrl_w === 2'd1 && rel(data_w),
                            128'({busy_v[g], ctrl_w, data_w}),
                            128'({1'b1, 2'd1, 16'h0}));
                    end else begin
                        chk($sformatf("release%0d", g),
                            !busy_v[g] && rel({14'h0, ctrl_w}) && rel(data_w),
                            128'({busy_v[g], ctrl_w, data_w}),
                            128'({1'b0, 2'd0, 16'h0}));
                    end
                end else if (tb_cen) begin
                    chk($sformatf("bus_clash%0d", g), ctrl_w === tb_cval,
                        128'(ctrl_w), 128'(tb_cval));
                end else begin
                    chk($sformatf("no_resp%0d", g), ctrl_w !== 2'd1,
                        128'(ctrl_w), 128'(0));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke_busy();
        tb_cen  = 1'b1;
        tb_cval = ($urandom_range(0, 1) == 1) ? 2'd2 : 2'd3;
        addr    = 14'($urandom);
        tick();
        tb_cen  = 1'b0;
    endtask

    task automatic do_write(input logic [13:0] a, input logic [127:0] ln,
                            input bit ign);
        tick();
        addr    = a;
        tb_cen  = 1'b1;
        tb_cval = 2'd3;
        tb_den  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tb_dval = ln[16*k +: 16];
            tick();
        end
        tb_cen = 1'b0;
        tb_den = 1'b0;
        ref_mem[int'(a)] = ln;
        for (int g = 0; g < NI; g++) begin
            push(g, cyc + LATS[g], 1, '0);
            push(g, cyc + LATS[g] + 1, 2, '0);
        end
        if (ign) poke_busy();
    endtask

    task automatic do_read(input logic [13:0] a, input bit ign);
        logic [127:0] ln;
        tick();
        addr    = a;
        tb_cen  = 1'b1;
        tb_cval = 2'd2;
        tick();
        tb_cen  = 1'b0;
        ln      = ref_rd(a);
        for (int g = 0; g < NI; g++) begin
            for (int k = 0; k < 8; k++) push(g, cyc + LATS[g] + k, 0, ln[16*k +: 16]);
            push(g, cyc + LATS[g] + 8, 2, '0);
        end
        if (ign) poke_busy();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 1000 && !(busy_v == '0 && sbq.size() == 0)) begin
            tick();
            n++;
        end
        chk("idle_timeout", n < 1000, 128'(n), 128'(1000));
    endtask

    task automatic rst_pulse();
        tb_cen = 1'b0;
        tb_den = 1'b0;
        reset  = 1'b0;
        #1;
        chk("rst_busy", busy_v == '0, 128'(busy_v), 128'(0));
        chk("rst_bus",
            rel(gi[0].data_w) && rel(gi[1].data_w) && rel(gi[2].data_w) &&
            rel({14'h0, gi[0].ctrl_w}) && rel({14'h0, gi[1].ctrl_w}) &&
            rel({14'h0, gi[2].ctrl_w}),
            128'({gi[0].ctrl_w, gi[1].ctrl_w, gi[2].ctrl_w}), 128'(0));
        sbq.delete();
        repeat (2) tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [13:0] ra;
        repeat (3) tick();
        rst_pulse();

        do_read(14'h3fff, 1'b0);
        wait_idle();
        do_write(14'h0, 128'h4444_3333_2222_1111_ffff_aa66_0000_1234, 1'b0);
        wait_idle();
        do_read(14'h0, 1'b1);
        wait_idle();

        repeat (30) begin
            ra = ($urandom_range(0, 7) == 0) ? 14'h3fff : 14'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                do_write(ra, {$urandom, $urandom, $urandom, $urandom},
                         bit'($urandom_range(0, 1)));
            end else begin
                do_read(ra, bit'($urandom_range(0, 1)));
            end
            wait_idle();
        end

        tick();
        addr    = 14'd7;
        tb_cen  = 1'b1;
        tb_cval = 2'd3;
        tb_den  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tb_dval = 16'($urandom);
            tick();
        end
        chk("busy_mid_wr", busy_v == '1, 128'(busy_v), 128'(3'b111));
        rst_pulse();
        do_read(14'd7, 1'b0);
        wait_idle();

`ifdef C2_PROTO_CHECK_EN
        tick();
        rst_pulse();
        chk("perr_rst", perr_v == '0, 128'(perr_v), 128'(0));
        tick();
        addr    = 14'd9;
        tb_cen  = 1'b1;
        tb_cval = 2'd3;
        tb_den  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) tb_cval = 2'd0;
            tb_dval = 16'($urandom);
            tick();
        end
        tb_cen = 1'b0;
        tb_den = 1'b0;
        chk("perr_set", perr_v == '1, 128'(perr_v), 128'(3'b111));
        chk("abort_idle", busy_v == '0, 128'(busy_v), 128'(0));
        repeat (300) tick();
        do_read(14'd9, 1'b0);
        wait_idle();
        chk("perr_sticky", perr_v == '1, 128'(perr_v), 128'(3'b111));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
